// File: rtl/banked_sp_ram_pm_if.sv
// Core-side memory port of banked_sp_ram_pm: req/gnt request phase plus a
// one-cycle-later rvalid response phase.
interface banked_sp_ram_pm_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
);
   logic                    req_i;
   logic                    gnt_o;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic                    we_i;
   logic [DATA_WIDTH/8-1:0] be_i;
   logic [DATA_WIDTH-1:0]   wdata_i;
   logic                    rvalid_o;
   logic [DATA_WIDTH-1:0]   rdata_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/banked_sp_ram_pm.sv
// Banked single-port RAM with per-bank idle sleep and on-demand wake.
// Optional macro SP_RAM_WAKE_CNT_EN adds a saturating SLEEP->WAKE event counter.

module banked_sp_ram_pm_bank #(
   parameter int SLEEP_IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req,
   input  logic       i_gnt,
   output logic [1:0] o_state
);
   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_SLEEP  = 2'd1;
   localparam logic [1:0] ST_WAKE   = 2'd2;
   localparam int ICW = (SLEEP_IDLE_CYCLES < 2) ? 1 : $clog2(SLEEP_IDLE_CYCLES);
   localparam int WCW = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES);

   logic [1:0]     r_state;
   logic [ICW-1:0] r_idle;
   logic [WCW-1:0] r_wcnt;
   logic           w_idle_hit;

   assign w_idle_hit = (SLEEP_IDLE_CYCLES != 0) && (r_idle == ICW'(SLEEP_IDLE_CYCLES - 1));
   assign o_state    = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ACTIVE;
         r_idle  <= '0;
         r_wcnt  <= '0;
      end else begin
         case (r_state)
            ST_ACTIVE: begin
               // a grant in the threshold cycle wins over going to sleep
               if (i_gnt) begin
                  r_idle <= '0;
               end else begin
                  if (w_idle_hit) r_state <= ST_SLEEP;
                  if (r_idle != '1) r_idle <= r_idle + 1'b1;
               end
            end
            ST_SLEEP: begin
               if (i_req) begin
                  r_wcnt  <= WCW'(WAKE_CYCLES - 1);
                  r_state <= ST_WAKE;
               end
            end
            ST_WAKE: begin
               if (r_wcnt == '0) begin
                  r_state <= ST_ACTIVE;
                  r_idle  <= '0;
               end else begin
                  r_wcnt <= r_wcnt - 1'b1;
               end
            end
            default: r_state <= ST_ACTIVE;
         endcase
      end
   end
endmodule

module banked_sp_ram_pm #(
   parameter int ADDR_WIDTH        = 15,
   parameter int DATA_WIDTH        = 32,
   parameter int NUM_BANKS         = 4,
   parameter int BANK_WORDS        = 2048,
   parameter int SLEEP_IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   banked_sp_ram_pm_if.slave     bus,
   output logic [NUM_BANKS-1:0]  bank_sleep_o,
   output logic [15:0]           wake_cnt_o
);
   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int WORD_BITS = $clog2(BANK_WORDS);
   localparam int NBYTES    = DATA_WIDTH / 8;
   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_SLEEP  = 2'd1;

   logic [BANK_BITS-1:0]           w_bank;
   logic [WORD_BITS-1:0]           w_word;
   logic [BANK_BITS+WORD_BITS-1:0] w_idx;
   logic [NUM_BANKS-1:0]           w_active;
   logic [NUM_BANKS-1:0][1:0]      w_state;
   logic                           w_acc;
   logic                           w_unused_addr;
   logic                           r_rvalid;
   logic [DATA_WIDTH-1:0]          r_rdata;
   logic [DATA_WIDTH-1:0]          r_mem [0:NUM_BANKS*BANK_WORDS-1];

   assign w_bank        = bus.addr_i[ADDR_WIDTH-1 -: BANK_BITS];
   assign w_word        = bus.addr_i[WORD_BITS+1:2];
   assign w_idx         = {w_bank, w_word};
   assign w_unused_addr = ^bus.addr_i[1:0];

   assign bus.gnt_o    = bus.req_i & w_active[w_bank];
   // a grant seen during reset performs no access and yields no response
   assign w_acc        = bus.gnt_o & ~rst;
   assign bus.rvalid_o = r_rvalid;
   assign bus.rdata_o  = r_rdata;

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      banked_sp_ram_pm_bank #(
         .SLEEP_IDLE_CYCLES (SLEEP_IDLE_CYCLES),
         .WAKE_CYCLES       (WAKE_CYCLES)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .i_req   (bus.req_i & (w_bank == BANK_BITS'(g))),
         .i_gnt   (w_acc & (w_bank == BANK_BITS'(g))),
         .o_state (w_state[g])
      );
      assign w_active[g]     = (w_state[g] == ST_ACTIVE);
      assign bank_sleep_o[g] = ~w_active[g];
   end

   always_ff @(posedge clk) begin
      if (w_acc && bus.we_i) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (bus.be_i[k]) r_mem[w_idx][k*8 +: 8] <= bus.wdata_i[k*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_acc;
         if (w_acc && !bus.we_i) r_rdata <= r_mem[w_idx];
      end
   end

`ifdef SP_RAM_WAKE_CNT_EN
   logic [NUM_BANKS-1:0] w_wake_evt;
   logic [16:0]          w_wake_sum;
   logic [15:0]          r_wake_cnt;

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_wake_evt
      assign w_wake_evt[g] = (w_state[g] == ST_SLEEP) & bus.req_i & (w_bank == BANK_BITS'(g));
   end

   always_comb begin
      w_wake_sum = {1'b0, r_wake_cnt};
      for (int k = 0; k < NUM_BANKS; k++) w_wake_sum = w_wake_sum + 17'(w_wake_evt[k]);
   end

   always_ff @(posedge clk) begin
      if (rst) r_wake_cnt <= '0;
      else     r_wake_cnt <= w_wake_sum[16] ? 16'hFFFF : w_wake_sum[15:0];
   end

   assign wake_cnt_o = r_wake_cnt;
`else
   assign wake_cnt_o = '0;
`endif
endmodule
